// File: rtl/brp_gshare_pkg.sv
// Shared branch-prediction types for the RV32I pipeline: the prediction word
// carried IF->ID->EX and the saturating-counter constants.
package rv32i_types;

   localparam int BRP_GHR_W = 8;

   typedef struct packed {
      logic                 taken;
      logic [31:0]          target;
      logic [BRP_GHR_W-1:0] ghr;
   } rv32i_brp_word;

   // Weakly not-taken: just below the taken threshold (MSB clear)
   function automatic int unsigned ctr_weak_nt(input int unsigned w);
      return (32'd1 << (w - 1)) - 32'd1;
   endfunction

   // Weakly taken: smallest value with the MSB set
   function automatic int unsigned ctr_weak_t(input int unsigned w);
      return 32'd1 << (w - 1);
   endfunction

endpackage

// File: rtl/brp_gshare_sat.sv
// Untagged table of saturating counters: async read port for lookup, one
// write port that either loads a value or steps the addressed counter.
module sat_counter_table #(
   parameter int               DEPTH   = 256,
   parameter int               CTR_W   = 2,
   parameter logic [CTR_W-1:0] RST_VAL = '0,
   localparam int              AW      = $clog2(DEPTH)
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic [AW-1:0]    rd_addr_i,
   output logic [CTR_W-1:0] rd_ctr_o,
   input  logic             wr_en_i,
   input  logic [AW-1:0]    wr_addr_i,
   input  logic             wr_set_i,
   input  logic [CTR_W-1:0] wr_set_val_i,
   input  logic             wr_inc_i
);

   localparam logic [CTR_W-1:0] CTR_MAX = {CTR_W{1'b1}};

   logic [CTR_W-1:0] ctr_q [DEPTH];
   logic [CTR_W-1:0] cur;
   logic [CTR_W-1:0] ctr_d;

   assign rd_ctr_o = ctr_q[rd_addr_i];
   assign cur      = ctr_q[wr_addr_i];

   always_comb begin
      ctr_d = cur;
      if (wr_set_i)
         ctr_d = wr_set_val_i;
      else if (wr_inc_i)
         ctr_d = (cur == CTR_MAX) ? cur : cur + CTR_W'(1);
      else
         ctr_d = (cur == '0) ? cur : cur - CTR_W'(1);
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         for (int i = 0; i < DEPTH; i++) ctr_q[i] <= RST_VAL;
      end else if (wr_en_i) begin
         ctr_q[wr_addr_i] <= ctr_d;
      end
   end

endmodule

// File: rtl/brp_gshare.sv
// Dynamic branch predictor: direct-mapped BTB plus gshare/bimodal PHT, looked
// up combinationally in IF and trained / history-repaired from EX.
module brp_gshare
   import rv32i_types::*;
#(
   parameter int BTB_ENTRIES = 64,
   parameter int PHT_ENTRIES = 256,
   parameter int GHR_W       = 8,
   parameter int TAG_W       = 10,
   parameter int CTR_W       = 2,
   parameter int GSHARE      = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic [31:0]      pred_pc,
   input  logic             pred_req,
   output logic             pred_taken,
   output logic [31:0]      pred_target,
   output logic [GHR_W-1:0] pred_ghr,
   input  logic             upd_valid,
   input  logic [31:0]      upd_pc,
   input  logic             upd_is_br,
   input  logic             upd_taken,
   input  logic [31:0]      upd_target,
   input  logic [GHR_W-1:0] upd_ghr,
   input  logic             upd_mispredict
);

   localparam int BTB_IW = $clog2(BTB_ENTRIES);
   localparam int PHT_IW = $clog2(PHT_ENTRIES);
   localparam logic [CTR_W-1:0] CTR_WNT = CTR_W'(ctr_weak_nt(CTR_W));
   localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(ctr_weak_t(CTR_W));

   function automatic logic [PHT_IW-1:0] pht_idx(input logic [31:0] pc,
                                                 input logic [GHR_W-1:0] h);
      logic [PHT_IW-1:0] base;
      base = pc[PHT_IW+1:2];
      return (GSHARE != 0) ? (base ^ PHT_IW'(h)) : base;
   endfunction

   logic [BTB_ENTRIES-1:0] btb_vld_q;
   logic [TAG_W-1:0]       btb_tag_q [BTB_ENTRIES];
   logic [31:0]            btb_tgt_q [BTB_ENTRIES];
   logic                   btb_jal_q [BTB_ENTRIES];
   logic [GHR_W-1:0]       ghr_q, ghr_d;

   logic [BTB_IW-1:0] p_idx, u_idx;
   logic [TAG_W-1:0]  p_tag, u_tag;
   logic              p_hit, u_hit;
   logic              p_is_br;
   logic [CTR_W-1:0]  p_ctr;
   logic              p_dir;
   logic              btb_we;
   logic              pht_we, pht_set;
   logic              unused_pc;

   assign unused_pc = ^{pred_pc, upd_pc};

   // Lookup side
   assign p_idx   = pred_pc[BTB_IW+1:2];
   assign p_tag   = pred_pc[BTB_IW+2 +: TAG_W];
   assign p_hit   = btb_vld_q[p_idx] && (btb_tag_q[p_idx] == p_tag);
   assign p_is_br = !btb_jal_q[p_idx];
   assign p_dir   = p_ctr[CTR_W-1];

   always_comb begin
      pred_taken  = 1'b0;
      pred_target = '0;
      pred_ghr    = '0;
      if (rst) begin
         pred_taken  = pred_req && p_hit && (!p_is_br || p_dir);
         pred_target = p_hit ? btb_tgt_q[p_idx] : pred_pc + 32'd4;
         pred_ghr    = ghr_q;
      end
   end

   // Update side: taken outcomes (re)write the BTB; a branch missing the BTB
   // gets its counter primed to weakly taken instead of stepped.
   assign u_idx   = upd_pc[BTB_IW+1:2];
   assign u_tag   = upd_pc[BTB_IW+2 +: TAG_W];
   assign u_hit   = btb_vld_q[u_idx] && (btb_tag_q[u_idx] == u_tag);
   assign btb_we  = upd_valid && upd_taken;
   assign pht_we  = upd_valid && upd_is_br;
   assign pht_set = upd_taken && !u_hit;

   sat_counter_table #(
      .DEPTH   (PHT_ENTRIES),
      .CTR_W   (CTR_W),
      .RST_VAL (CTR_WNT)
   ) u_pht (
      .clk_i        (clk),
      .rst_n_i      (rst),
      .rd_addr_i    (pht_idx(pred_pc, ghr_q)),
      .rd_ctr_o     (p_ctr),
      .wr_en_i      (pht_we),
      .wr_addr_i    (pht_idx(upd_pc, upd_ghr)),
      .wr_set_i     (pht_set),
      .wr_set_val_i (CTR_WT),
      .wr_inc_i     (upd_taken)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         btb_vld_q <= '0;
      else if (btb_we)
         btb_vld_q[u_idx] <= 1'b1;
   end

   always_ff @(posedge clk) begin
      if (btb_we) begin
         btb_tag_q[u_idx] <= u_tag;
         btb_tgt_q[u_idx] <= upd_target;
         btb_jal_q[u_idx] <= !upd_is_br;
      end
   end

   // Branch repair from EX outranks the speculative shift and ignores stall
   always_comb begin
      ghr_d = ghr_q;
      if (upd_valid && upd_mispredict && upd_is_br)
         ghr_d = {upd_ghr[GHR_W-2:0], upd_taken};
      else if (pred_req && p_hit && p_is_br && !stall)
         ghr_d = {ghr_q[GHR_W-2:0], p_dir};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         ghr_q <= '0;
      else
         ghr_q <= ghr_d;
   end

endmodule
